// File: rtl/xmega_alu_wb_seq_if.sv
// Issue bus from the decoder/ALU into the write-back sequencer.
// The decoder side drives the master modport, the sequencer consumes the slave modport.
interface xmega_alu_wb_seq_if;
  logic        iss_valid;
  logic        iss_ready;
  logic [1:0]  iss_kind;
  logic [4:0]  iss_rda;
  logic [15:0] iss_res;
  logic [7:0]  iss_sreg;
  logic        iss_sreg_we;

  modport master (
    output iss_valid, iss_kind, iss_rda, iss_res, iss_sreg, iss_sreg_we,
    input  iss_ready
  );

  modport slave (
    input  iss_valid, iss_kind, iss_rda, iss_res, iss_sreg, iss_sreg_we,
    output iss_ready
  );
endinterface

// File: rtl/xmega_alu_wb_seq.sv
// Write-back sequencer between the xmega ALU and the single-write-port register file.
// Splits word results into two byte writes and owns the architectural SREG.
module xmega_alu_wb_seq #(
  parameter logic [7:0] SREG_RESET = 8'h00,
  parameter bit         HAS_MUL    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  xmega_alu_wb_seq_if.slave         iss,
  input  logic                      io_sreg_we,
  input  logic [7:0]                io_sreg_d,
  input  logic                      flush,
  output logic                      rf_we,
  output logic [4:0]                rf_addr,
  output logic [7:0]                rf_data,
  output logic [7:0]                sreg_q,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic {
    IDLE  = 1'b0,
    WR_HI = 1'b1
  } state_t;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_BYTE = 2'b01;
  localparam logic [1:0] KIND_WORD = 2'b10;
  localparam logic [1:0] KIND_MUL  = 2'b11;

  state_t     state_q, state_d;
  logic [4:0] hi_addr_q, hi_addr_d;
  logic [7:0] hi_data_q, hi_data_d;
  logic       rf_we_d, busy_d, err_d;
  logic [4:0] rf_addr_d;
  logic [7:0] rf_data_d;
  logic [7:0] sreg_d;
  logic       accept;
  logic       mul_drop;

  // Ready depends on state only so the decoder never sees a valid->ready loop.
  assign iss.iss_ready = rst & (state_q != WR_HI);
  assign accept        = iss.iss_valid & iss.iss_ready & ~flush;
  assign mul_drop      = (iss.iss_kind == KIND_MUL) & ~HAS_MUL;

  always_comb begin
    state_d   = state_q;
    hi_addr_d = hi_addr_q;
    hi_data_d = hi_data_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr;
    rf_data_d = rf_data;
    busy_d    = 1'b0;
    err_d     = 1'b0;
    sreg_d    = sreg_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (mul_drop) begin
            err_d = 1'b1;
          end else begin
            if (iss.iss_sreg_we) sreg_d = iss.iss_sreg;
            unique case (iss.iss_kind)
              KIND_NONE: ;
              KIND_BYTE: begin
                rf_we_d   = 1'b1;
                rf_addr_d = iss.iss_rda;
                rf_data_d = iss.iss_res[7:0];
              end
              KIND_WORD: begin
                rf_we_d   = 1'b1;
                rf_addr_d = {iss.iss_rda[4:1], 1'b0};
                rf_data_d = iss.iss_res[7:0];
                hi_addr_d = {iss.iss_rda[4:1], 1'b1};
                hi_data_d = iss.iss_res[15:8];
                busy_d    = 1'b1;
                state_d   = WR_HI;
              end
              KIND_MUL: begin
                rf_we_d   = 1'b1;
                rf_addr_d = 5'd0;
                rf_data_d = iss.iss_res[7:0];
                hi_addr_d = 5'd1;
                hi_data_d = iss.iss_res[15:8];
                busy_d    = 1'b1;
                state_d   = WR_HI;
              end
              default: ;
            endcase
          end
        end
      end
      WR_HI: begin
        // A flush here only cancels the high byte; the low byte is already committed.
        state_d = IDLE;
        if (!flush) begin
          rf_we_d   = 1'b1;
          rf_addr_d = hi_addr_q;
          rf_data_d = hi_data_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (io_sreg_we) sreg_d = io_sreg_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hi_addr_q <= 5'd0;
      hi_data_q <= 8'h00;
      rf_we     <= 1'b0;
      rf_addr   <= 5'd0;
      rf_data   <= 8'h00;
      busy      <= 1'b0;
      err       <= 1'b0;
      sreg_q    <= SREG_RESET;
    end else begin
      state_q   <= state_d;
      hi_addr_q <= hi_addr_d;
      hi_data_q <= hi_data_d;
      rf_we     <= rf_we_d;
      rf_addr   <= rf_addr_d;
      rf_data   <= rf_data_d;
      busy      <= busy_d;
      err       <= err_d;
      sreg_q    <= sreg_d;
    end
  end

endmodule

// File: tb/tb_xmega_alu_wb_seq.sv
// Directed, table-driven bench for xmega_alu_wb_seq, plus a HAS_MUL=0 instance.
module tb_xmega_alu_wb_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       io_sreg_we;
  logic [7:0] io_sreg_d;
  logic       flush;

  logic       rf_we, busy, err;
  logic [4:0] rf_addr;
  logic [7:0] rf_data, sreg_q;

  logic       n_rf_we, n_busy, n_err;
  logic [4:0] n_rf_addr;
  logic [7:0] n_rf_data, n_sreg_q;

  int checks   = 0;
  int failures = 0;

  xmega_alu_wb_seq_if bus ();
  xmega_alu_wb_seq_if nbus ();

  xmega_alu_wb_seq #(.SREG_RESET(8'h80), .HAS_MUL(1'b1)) dut (
    .clk(clk), .rst(rst), .iss(bus.slave),
    .io_sreg_we(io_sreg_we), .io_sreg_d(io_sreg_d), .flush(flush),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .sreg_q(sreg_q), .busy(busy), .err(err)
  );

  xmega_alu_wb_seq #(.SREG_RESET(8'h80), .HAS_MUL(1'b0)) dut_nomul (
    .clk(clk), .rst(rst), .iss(nbus.slave),
    .io_sreg_we(io_sreg_we), .io_sreg_d(io_sreg_d), .flush(flush),
    .rf_we(n_rf_we), .rf_addr(n_rf_addr), .rf_data(n_rf_data),
    .sreg_q(n_sreg_q), .busy(n_busy), .err(n_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  kind;
    logic [4:0]  rda;
    logic [15:0] res;
    logic [7:0]  sreg;
    logic        sreg_we;
    logic        io_we;
    logic [7:0]  io_d;
    logic        fl;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [7:0]  exp_data;
    logic [7:0]  exp_sreg;
    logic        exp_busy;
    logic        exp_ready;
    logic        exp_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.iss_valid   = v.valid;
    bus.iss_kind    = v.kind;
    bus.iss_rda     = v.rda;
    bus.iss_res     = v.res;
    bus.iss_sreg    = v.sreg;
    bus.iss_sreg_we = v.sreg_we;
    io_sreg_we      = v.io_we;
    io_sreg_d       = v.io_d;
    flush           = v.fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // valid kind  rda    res        sreg   swe  iowe io_d  fl | we addr   data   sreg   busy rdy err
    vecs[0]  = '{1'b1, 2'b01, 5'd16, 16'h005A, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 8'h5A, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 2'b10, 5'd24, 16'h1234, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd24, 8'h34, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 5'd24, 16'h1234, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd25, 8'h12, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 5'd0,  16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd25, 8'h12, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 2'b11, 5'd7,  16'hBEEF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0,  8'hEF, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 5'd0,  16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd1,  8'hBE, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 2'b10, 5'd25, 16'hA55A, 8'h15, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd24, 8'h5A, 8'h15, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 5'd0,  16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd24, 8'h5A, 8'h15, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 2'b01, 5'd3,  16'h0077, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd3,  8'h77, 8'h15, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 2'b01, 5'd5,  16'h0011, 8'h3F, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd3,  8'h77, 8'h15, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 2'b00, 5'd0,  16'h0000, 8'h03, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 5'd3,  8'h77, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 5'd0,  16'h0000, 8'h00, 1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 5'd3,  8'h77, 8'h42, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 2'b00, 5'd9,  16'hFFFF, 8'h07, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd3,  8'h77, 8'h07, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 2'b10, 5'd30, 16'hCAFE, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd30, 8'hFE, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 5'd0,  16'h0000, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 5'd31, 8'hCA, 8'h99, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 2'b01, 5'd1,  16'h0010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd1,  8'h10, 8'h99, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 2'b01, 5'd2,  16'hFF11, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd2,  8'h11, 8'h99, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 2'b01, 5'd3,  16'h0012, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd3,  8'h12, 8'h99, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 2'b01, 5'd4,  16'h0013, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd4,  8'h13, 8'h99, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 2'b00, 5'd0,  16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd4,  8'h13, 8'h99, 1'b0, 1'b1, 1'b0};

    rst = 1'b0;
    applyStimulus(vecs[19]);
    bus.iss_valid    = 1'b0;
    nbus.iss_valid   = 1'b0;
    nbus.iss_kind    = 2'b00;
    nbus.iss_rda     = 5'd0;
    nbus.iss_res     = 16'h0000;
    nbus.iss_sreg    = 8'h00;
    nbus.iss_sreg_we = 1'b0;
    repeat (2) tick();

    checkOutput("rst.we",    {15'd0, rf_we},         16'd0);
    checkOutput("rst.addr",  {11'd0, rf_addr},       16'd0);
    checkOutput("rst.data",  {8'd0, rf_data},        16'd0);
    checkOutput("rst.sreg",  {8'd0, sreg_q},         16'h80);
    checkOutput("rst.busy",  {15'd0, busy},          16'd0);
    checkOutput("rst.err",   {15'd0, err},           16'd0);
    checkOutput("rst.ready", {15'd0, bus.iss_ready}, 16'd0);

    rst = 1'b1;
    #1;
    checkOutput("rel.ready", {15'd0, bus.iss_ready}, 16'd1);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d.we", i),    {15'd0, rf_we},         {15'd0, vecs[i].exp_we});
      checkOutput($sformatf("v%0d.addr", i),  {11'd0, rf_addr},       {11'd0, vecs[i].exp_addr});
      checkOutput($sformatf("v%0d.data", i),  {8'd0, rf_data},        {8'd0, vecs[i].exp_data});
      checkOutput($sformatf("v%0d.sreg", i),  {8'd0, sreg_q},         {8'd0, vecs[i].exp_sreg});
      checkOutput($sformatf("v%0d.busy", i),  {15'd0, busy},          {15'd0, vecs[i].exp_busy});
      checkOutput($sformatf("v%0d.ready", i), {15'd0, bus.iss_ready}, {15'd0, vecs[i].exp_ready});
      checkOutput($sformatf("v%0d.err", i),   {15'd0, err},           {15'd0, vecs[i].exp_err});
    end

    // Reset asserted while the high byte of a word write is still pending.
    bus.iss_valid = 1'b1;
    bus.iss_kind  = 2'b10;
    bus.iss_rda   = 5'd10;
    bus.iss_res   = 16'h4321;
    tick();
    bus.iss_valid = 1'b0;
    checkOutput("rmid.busy", {15'd0, busy},    16'd1);
    checkOutput("rmid.data", {8'd0, rf_data},  16'h21);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rmid.we",    {15'd0, rf_we},         16'd0);
    checkOutput("rmid.sreg",  {8'd0, sreg_q},         16'h80);
    checkOutput("rmid.busy0", {15'd0, busy},          16'd0);
    checkOutput("rmid.ready", {15'd0, bus.iss_ready}, 16'd0);
    checkOutput("rmid.addr",  {11'd0, rf_addr},       16'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("rpost.we",    {15'd0, rf_we},         16'd0);
    checkOutput("rpost.ready", {15'd0, bus.iss_ready}, 16'd1);

    // MUL kind on a core built without a multiplier.
    nbus.iss_valid = 1'b1;
    nbus.iss_kind  = 2'b11;
    nbus.iss_rda   = 5'd7;
    nbus.iss_res   = 16'hBEEF;
    tick();
    checkOutput("nomul.err",   {15'd0, n_err},          16'd1);
    checkOutput("nomul.we",    {15'd0, n_rf_we},        16'd0);
    checkOutput("nomul.busy",  {15'd0, n_busy},         16'd0);
    checkOutput("nomul.ready", {15'd0, nbus.iss_ready}, 16'd1);
    nbus.iss_kind = 2'b01;
    nbus.iss_rda  = 5'd9;
    nbus.iss_res  = 16'h0066;
    tick();
    checkOutput("nomul.err1",  {15'd0, n_err},     16'd0);
    checkOutput("nomul.bwe",   {15'd0, n_rf_we},   16'd1);
    checkOutput("nomul.baddr", {11'd0, n_rf_addr}, 16'd9);
    checkOutput("nomul.bdata", {8'd0, n_rf_data},  16'h66);
    nbus.iss_valid = 1'b0;
    tick();
    checkOutput("nomul.idle", {15'd0, n_rf_we}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
